// File: rtl/mcpu_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, opcodes, ALU ops and mux selects.
package mcpu_ctrl_fsm_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_IF      = 4'd1,
      S_ID      = 4'd2,
      S_EX_R    = 4'd3,
      S_EX_I    = 4'd4,
      S_EX_ADDR = 4'd5,
      S_MEM_RD  = 4'd6,
      S_MEM_WR  = 4'd7,
      S_WB_MEM  = 4'd8,
      S_WB_ALU  = 4'd9,
      S_EX_BR   = 4'd10,
      S_EX_JAL  = 4'd11,
      S_EX_JALR = 4'd12,
      S_WB_LUI  = 4'd13,
      S_ERR     = 4'd14
   } state_t;

   localparam logic [4:0] OP_R     = 5'b01100;
   localparam logic [4:0] OP_I     = 5'b00100;
   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_STORE = 5'b01000;
   localparam logic [4:0] OP_BR    = 5'b11000;
   localparam logic [4:0] OP_JAL   = 5'b11011;
   localparam logic [4:0] OP_JALR  = 5'b11001;
   localparam logic [4:0] OP_LUI   = 5'b01101;

   // ALU codes are {Fun7, Fun3} so R-type decode is a plain concatenation
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam logic [1:0] MTR_ALU = 2'd0;
   localparam logic [1:0] MTR_MDR = 2'd1;
   localparam logic [1:0] MTR_PC  = 2'd2;
   localparam logic [1:0] MTR_IMM = 2'd3;

   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_ALUOUT = 2'd1;
   localparam logic [1:0] PCS_JALR   = 2'd2;

   localparam logic       SRCA_PC  = 1'b0;
   localparam logic       SRCA_RS1 = 1'b1;
   localparam logic [1:0] SRCB_RS2 = 2'd0;
   localparam logic [1:0] SRCB_4   = 2'd1;
   localparam logic [1:0] SRCB_IMM = 2'd2;

   // States that hold a bus request and may stall on MIO_ready
   function automatic logic is_wait_state(state_t s);
      return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mcpu_ctrl_fsm_if.sv
// Instruction-field inputs and datapath control outputs of the multi-cycle controller.
interface mcpu_ctrl_fsm_if
   import mcpu_ctrl_fsm_pkg::*;
   #(parameter int RETIRE_W = 32);

   logic [4:0]          OPcode;
   logic [2:0]          Fun3;
   logic                Fun7;
   logic                zero;
   logic                MIO_ready;
   logic                CPU_MIO;
   logic                MemRW;
   logic                IorD;
   logic                IRWrite;
   logic                PCWrite;
   logic [1:0]          PCSource;
   logic                ALUSrc_A;
   logic [1:0]          ALUSrc_B;
   logic [2:0]          ImmSel;
   logic [3:0]          ALU_Control;
   logic [1:0]          MemtoReg;
   logic                RegWrite;
   logic                bus_err;
   logic [RETIRE_W-1:0] retired;
   state_t              state_out;

   modport master (
      input  OPcode, Fun3, Fun7, zero, MIO_ready,
      output CPU_MIO, MemRW, IorD, IRWrite, PCWrite, PCSource, ALUSrc_A, ALUSrc_B,
             ImmSel, ALU_Control, MemtoReg, RegWrite, bus_err, retired, state_out
   );

   modport slave (
      output OPcode, Fun3, Fun7, zero, MIO_ready,
      input  CPU_MIO, MemRW, IorD, IRWrite, PCWrite, PCSource, ALUSrc_A, ALUSrc_B,
             ImmSel, ALU_Control, MemtoReg, RegWrite, bus_err, retired, state_out
   );

endinterface

// File: rtl/mcpu_ctrl_fsm_alu_dec.sv
// ALU operation decode from the current state and Fun3/Fun7 fields.
module mcpu_ctrl_fsm_alu_dec
   import mcpu_ctrl_fsm_pkg::*;
(
   input  state_t     state,
   input  logic [2:0] fun3,
   input  logic       fun7,
   output logic [3:0] alu_control
);

   // Immediate ops only honour bit 30 for srai; otherwise it is part of the immediate
   always_comb begin
      alu_control = ALU_ADD;
      case (state)
         S_EX_R:  alu_control = {fun7, fun3};
         S_EX_I:  alu_control = {fun7 & (fun3 == 3'b101), fun3};
         S_EX_BR: alu_control = ALU_SUB;
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle RV32I control FSM with bus wait states, timeout trap and retired-instruction counter.
module mcpu_ctrl_fsm
   import mcpu_ctrl_fsm_pkg::*;
#(
   parameter int WAIT_MAX = 16,
   parameter int RETIRE_W = 32
)
(
   input  logic            clk,
   input  logic            rst,
   mcpu_ctrl_fsm_if.master bus
);

   localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   state_t              state;
   logic [CNT_W-1:0]    wait_cnt;
   logic [RETIRE_W-1:0] retired;
   logic                bus_err;
   logic                timeout;
   logic [3:0]          alu_control;

   // A ready arriving on the last allowed cycle still completes the transfer
   assign timeout = (WAIT_MAX > 0) && (wait_cnt == CNT_W'(WAIT_MAX - 1)) && !bus.MIO_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         retired  <= '0;
         bus_err  <= 1'b0;
      end else begin
         wait_cnt <= '0;
         case (state)
            S_IDLE: state <= S_IF;
            S_IF, S_MEM_RD, S_MEM_WR: begin
               if (bus.MIO_ready) begin
                  if (state == S_IF) begin
                     state <= S_ID;
                  end else if (state == S_MEM_RD) begin
                     state <= S_WB_MEM;
                  end else begin
                     state   <= S_IF;
                     retired <= retired + RETIRE_W'(1);
                  end
               end else if (timeout) begin
                  state   <= S_ERR;
                  bus_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_ID: begin
               case (bus.OPcode)
                  OP_R:             state <= S_EX_R;
                  OP_I:             state <= S_EX_I;
                  OP_LOAD, OP_STORE: state <= S_EX_ADDR;
                  OP_BR:            state <= S_EX_BR;
                  OP_JAL:           state <= S_EX_JAL;
                  OP_JALR:          state <= S_EX_JALR;
                  OP_LUI:           state <= S_WB_LUI;
                  default: begin
                     state   <= S_ERR;
                     bus_err <= 1'b1;
                  end
               endcase
            end
            S_EX_R, S_EX_I: state <= S_WB_ALU;
            S_EX_ADDR:      state <= (bus.OPcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_WB_MEM, S_WB_ALU, S_WB_LUI, S_EX_BR, S_EX_JAL, S_EX_JALR: begin
               state   <= S_IF;
               retired <= retired + RETIRE_W'(1);
            end
            S_ERR: state <= S_ERR;
            default: begin
               state   <= S_ERR;
               bus_err <= 1'b1;
            end
         endcase
      end
   end

   mcpu_ctrl_fsm_alu_dec u_alu_dec (
      .state       (state),
      .fun3        (bus.Fun3),
      .fun7        (bus.Fun7),
      .alu_control (alu_control)
   );

   // Moore decode; only IF write enables and branch PCWrite look at live inputs
   always_comb begin
      bus.CPU_MIO  = 1'b0;
      bus.MemRW    = 1'b0;
      bus.IorD     = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.PCSource = PCS_ALU;
      bus.ALUSrc_A = SRCA_PC;
      bus.ALUSrc_B = SRCB_RS2;
      bus.ImmSel   = IMM_I;
      bus.MemtoReg = MTR_ALU;
      bus.RegWrite = 1'b0;
      case (state)
         S_IF: begin
            bus.CPU_MIO  = 1'b1;
            bus.ALUSrc_B = SRCB_4;
            bus.IRWrite  = bus.MIO_ready;
            bus.PCWrite  = bus.MIO_ready;
         end
         S_ID: begin
            bus.ALUSrc_B = SRCB_IMM;
            bus.ImmSel   = IMM_B;
         end
         S_EX_R: bus.ALUSrc_A = SRCA_RS1;
         S_EX_I: begin
            bus.ALUSrc_A = SRCA_RS1;
            bus.ALUSrc_B = SRCB_IMM;
         end
         S_EX_ADDR: begin
            bus.ALUSrc_A = SRCA_RS1;
            bus.ALUSrc_B = SRCB_IMM;
            bus.ImmSel   = (bus.OPcode == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEM_RD: begin
            bus.CPU_MIO = 1'b1;
            bus.IorD    = 1'b1;
         end
         S_MEM_WR: begin
            bus.CPU_MIO = 1'b1;
            bus.IorD    = 1'b1;
            bus.MemRW   = 1'b1;
         end
         S_WB_MEM: begin
            bus.MemtoReg = MTR_MDR;
            bus.RegWrite = 1'b1;
         end
         S_WB_ALU: bus.RegWrite = 1'b1;
         S_EX_BR: begin
            bus.ALUSrc_A = SRCA_RS1;
            bus.PCWrite  = bus.zero ^ bus.Fun3[0];
            bus.PCSource = PCS_ALUOUT;
         end
         S_EX_JAL: begin
            bus.ALUSrc_B = SRCB_IMM;
            bus.ImmSel   = IMM_J;
            bus.PCWrite  = 1'b1;
            bus.MemtoReg = MTR_PC;
            bus.RegWrite = 1'b1;
         end
         S_EX_JALR: begin
            bus.ALUSrc_A = SRCA_RS1;
            bus.ALUSrc_B = SRCB_IMM;
            bus.PCWrite  = 1'b1;
            bus.PCSource = PCS_JALR;
            bus.MemtoReg = MTR_PC;
            bus.RegWrite = 1'b1;
         end
         S_WB_LUI: begin
            bus.ImmSel   = IMM_U;
            bus.MemtoReg = MTR_IMM;
            bus.RegWrite = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.ALU_Control = alu_control;
   assign bus.bus_err     = bus_err;
   assign bus.retired     = retired;
   assign bus.state_out   = state;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Directed bench for mcpu_ctrl_fsm: a default instance plus a WAIT_MAX=4 / RETIRE_W=4 instance on shared stimulus.
module tb_mcpu_ctrl_fsm;
   import mcpu_ctrl_fsm_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] op = 5'b0;
   logic [2:0] f3 = 3'b0;
   logic       f7 = 1'b0;
   logic       zero = 1'b0;
   logic       ready = 1'b1;
   int         total = 0;
   int         bad = 0;

   mcpu_ctrl_fsm_if #(.RETIRE_W(32)) bus_a ();
   mcpu_ctrl_fsm_if #(.RETIRE_W(4))  bus_b ();

   assign bus_a.OPcode = op;
   assign bus_a.Fun3 = f3;
   assign bus_a.Fun7 = f7;
   assign bus_a.zero = zero;
   assign bus_a.MIO_ready = ready;
   assign bus_b.OPcode = op;
   assign bus_b.Fun3 = f3;
   assign bus_b.Fun7 = f7;
   assign bus_b.zero = zero;
   assign bus_b.MIO_ready = ready;

   mcpu_ctrl_fsm #(.WAIT_MAX(16), .RETIRE_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   mcpu_ctrl_fsm #(.WAIT_MAX(4),  .RETIRE_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   // Enables packed as {CPU_MIO, MemRW, IorD, IRWrite, PCWrite, RegWrite}
   logic [5:0] en_a, en_b;
   assign en_a = {bus_a.CPU_MIO, bus_a.MemRW, bus_a.IorD, bus_a.IRWrite, bus_a.PCWrite, bus_a.RegWrite};
   assign en_b = {bus_b.CPU_MIO, bus_b.MemRW, bus_b.IorD, bus_b.IRWrite, bus_b.PCWrite, bus_b.RegWrite};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      op = OP_R; f3 = 3'b000; f7 = 1'b0; zero = 1'b0; ready = 1'b1;
      do_reset;
      total++;
      if (bus_a.state_out !== S_IDLE) begin bad++; $display("[TB] FAIL reset_state: got %0d want %0d", bus_a.state_out, S_IDLE); end
      total++;
      if ({en_a, bus_a.PCSource, bus_a.ALUSrc_B, bus_a.MemtoReg, bus_a.ALU_Control, bus_a.ImmSel} !== 19'd0) begin
         bad++; $display("[TB] FAIL reset_outputs: got en=%b pcs=%0d", en_a, bus_a.PCSource);
      end
      total++;
      if (bus_a.retired !== 32'd0 || bus_a.bus_err !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_counters: got retired=%0d err=%b want 0 0", bus_a.retired, bus_a.bus_err);
      end
   endtask

   task automatic test_r_type;
      state_t     exp_s[5]  = '{S_IF, S_ID, S_EX_R, S_WB_ALU, S_IF};
      logic [5:0] exp_en[5] = '{6'b100110, 6'b000000, 6'b000000, 6'b000001, 6'b100110};
      op = OP_R; f3 = 3'b000; f7 = 1'b0; ready = 1'b1;
      do_reset;
      for (int i = 0; i < 5; i++) begin
         tick;
         total++;
         if (bus_a.state_out !== exp_s[i] || en_a !== exp_en[i]) begin
            bad++; $display("[TB] FAIL add_step%0d: got state=%0d en=%b want state=%0d en=%b", i, bus_a.state_out, en_a, exp_s[i], exp_en[i]);
         end
      end
      total++;
      if (bus_a.retired !== 32'd1) begin bad++; $display("[TB] FAIL add_retired: got %0d want 1", bus_a.retired); end
      f7 = 1'b1;
      tick; tick;
      total++;
      if (bus_a.ALU_Control !== 4'b1000 || bus_a.ALUSrc_A !== 1'b1 || bus_a.ALUSrc_B !== 2'd0) begin
         bad++; $display("[TB] FAIL sub_decode: got alu=%b a=%b b=%0d want 1000 1 0", bus_a.ALU_Control, bus_a.ALUSrc_A, bus_a.ALUSrc_B);
      end
      tick; tick;
      total++;
      if (bus_a.retired !== 32'd2) begin bad++; $display("[TB] FAIL sub_retired: got %0d want 2", bus_a.retired); end
   endtask

   task automatic test_i_type;
      op = OP_I; f3 = 3'b101; f7 = 1'b1; ready = 1'b1;
      do_reset;
      tick; tick; tick;
      total++;
      if (bus_a.state_out !== S_EX_I || bus_a.ALU_Control !== 4'b1101 || bus_a.ALUSrc_B !== 2'd2 || bus_a.ImmSel !== 3'd0) begin
         bad++; $display("[TB] FAIL srai_decode: got state=%0d alu=%b b=%0d imm=%0d want %0d 1101 2 0", bus_a.state_out, bus_a.ALU_Control, bus_a.ALUSrc_B, bus_a.ImmSel, S_EX_I);
      end
      tick;
      total++;
      if (bus_a.state_out !== S_WB_ALU || en_a !== 6'b000001) begin
         bad++; $display("[TB] FAIL srai_wb: got state=%0d en=%b want %0d 000001", bus_a.state_out, en_a, S_WB_ALU);
      end
      f3 = 3'b000;
      tick; tick; tick;
      total++;
      if (bus_a.ALU_Control !== 4'b0000) begin bad++; $display("[TB] FAIL addi_bit30: got %b want 0000", bus_a.ALU_Control); end
   endtask

   task automatic test_load_wait;
      op = OP_LOAD; f3 = 3'b010; f7 = 1'b0; ready = 1'b1;
      do_reset;
      tick; tick; tick;
      total++;
      if (bus_a.state_out !== S_EX_ADDR || bus_a.ImmSel !== 3'd0 || bus_a.ALUSrc_A !== 1'b1 || bus_a.ALUSrc_B !== 2'd2) begin
         bad++; $display("[TB] FAIL lw_addr: got state=%0d imm=%0d a=%b b=%0d", bus_a.state_out, bus_a.ImmSel, bus_a.ALUSrc_A, bus_a.ALUSrc_B);
      end
      ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         total++;
         if (bus_a.state_out !== S_MEM_RD || en_a !== 6'b101000 || bus_a.bus_err !== 1'b0) begin
            bad++; $display("[TB] FAIL lw_wait%0d: got state=%0d en=%b err=%b want %0d 101000 0", i, bus_a.state_out, en_a, bus_a.bus_err, S_MEM_RD);
         end
         if (i == 5) ready = 1'b1;
      end
      total++;
      if (bus_b.state_out !== S_ERR || bus_b.bus_err !== 1'b1) begin
         bad++; $display("[TB] FAIL lw_short_timeout: got state=%0d err=%b want %0d 1", bus_b.state_out, bus_b.bus_err, S_ERR);
      end
      tick;
      total++;
      if (bus_a.state_out !== S_WB_MEM || en_a !== 6'b000001 || bus_a.MemtoReg !== 2'd1) begin
         bad++; $display("[TB] FAIL lw_wb: got state=%0d en=%b mtr=%0d want %0d 000001 1", bus_a.state_out, en_a, bus_a.MemtoReg, S_WB_MEM);
      end
      tick;
      total++;
      if (bus_a.state_out !== S_IF || bus_a.retired !== 32'd1) begin
         bad++; $display("[TB] FAIL lw_retire: got state=%0d retired=%0d want %0d 1", bus_a.state_out, bus_a.retired, S_IF);
      end
   endtask

   task automatic test_timeout;
      op = OP_R; ready = 1'b0;
      do_reset;
      for (int i = 0; i < 4; i++) begin
         tick;
         total++;
         if (bus_b.state_out !== S_IF || bus_b.bus_err !== 1'b0) begin
            bad++; $display("[TB] FAIL if_wait%0d: got state=%0d err=%b want %0d 0", i, bus_b.state_out, bus_b.bus_err, S_IF);
         end
      end
      tick;
      total++;
      if (bus_b.state_out !== S_ERR || bus_b.bus_err !== 1'b1 || en_b !== 6'b0) begin
         bad++; $display("[TB] FAIL if_timeout: got state=%0d err=%b en=%b want %0d 1 000000", bus_b.state_out, bus_b.bus_err, en_b, S_ERR);
      end
      ready = 1'b1;
      tick; tick; tick;
      total++;
      if (bus_b.state_out !== S_ERR || bus_b.bus_err !== 1'b1 || en_b !== 6'b0 || bus_b.retired !== 4'd0) begin
         bad++; $display("[TB] FAIL err_sticky: got state=%0d err=%b en=%b ret=%0d", bus_b.state_out, bus_b.bus_err, en_b, bus_b.retired);
      end
      ready = 1'b0;
      do_reset;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (i == 3) ready = 1'b1;
      end
      tick;
      total++;
      if (bus_b.state_out !== S_ID || bus_b.bus_err !== 1'b0) begin
         bad++; $display("[TB] FAIL ready_last_cycle: got state=%0d err=%b want %0d 0", bus_b.state_out, bus_b.bus_err, S_ID);
      end
   endtask

   task automatic test_branch;
      op = OP_BR; f3 = 3'b000; zero = 1'b1; ready = 1'b1;
      do_reset;
      tick; tick;
      total++;
      if (bus_a.ImmSel !== 3'd2 || bus_a.ALUSrc_B !== 2'd2 || bus_a.ALUSrc_A !== 1'b0) begin
         bad++; $display("[TB] FAIL id_target: got imm=%0d b=%0d a=%b want 2 2 0", bus_a.ImmSel, bus_a.ALUSrc_B, bus_a.ALUSrc_A);
      end
      tick;
      total++;
      if (bus_a.state_out !== S_EX_BR || bus_a.PCWrite !== 1'b1 || bus_a.PCSource !== 2'd1 || bus_a.ALU_Control !== 4'b1000) begin
         bad++; $display("[TB] FAIL beq_taken: got state=%0d pcw=%b pcs=%0d alu=%b", bus_a.state_out, bus_a.PCWrite, bus_a.PCSource, bus_a.ALU_Control);
      end
      tick;
      f3 = 3'b001;
      tick; tick;
      total++;
      if (bus_a.state_out !== S_EX_BR || bus_a.PCWrite !== 1'b0) begin
         bad++; $display("[TB] FAIL bne_not_taken: got state=%0d pcw=%b want %0d 0", bus_a.state_out, bus_a.PCWrite, S_EX_BR);
      end
      zero = 1'b0;
      #1;
      total++;
      if (bus_a.PCWrite !== 1'b1) begin bad++; $display("[TB] FAIL bne_taken: got pcw=%b want 1", bus_a.PCWrite); end
      tick;
      total++;
      if (bus_a.retired !== 32'd2) begin bad++; $display("[TB] FAIL branch_retired: got %0d want 2", bus_a.retired); end
   endtask

   task automatic test_illegal_and_abort;
      op = 5'b11111; f3 = 3'b000; ready = 1'b1;
      do_reset;
      tick; tick; tick;
      total++;
      if (bus_a.state_out !== S_ERR || bus_a.bus_err !== 1'b1 || en_a !== 6'b0) begin
         bad++; $display("[TB] FAIL illegal_op: got state=%0d err=%b en=%b want %0d 1 000000", bus_a.state_out, bus_a.bus_err, en_a, S_ERR);
      end
      op = OP_STORE;
      do_reset;
      total++;
      if (bus_a.bus_err !== 1'b0) begin bad++; $display("[TB] FAIL err_cleared: got %b want 0", bus_a.bus_err); end
      tick; tick; tick;
      total++;
      if (bus_a.ImmSel !== 3'd1) begin bad++; $display("[TB] FAIL sw_imm: got %0d want 1", bus_a.ImmSel); end
      ready = 1'b0;
      tick;
      total++;
      if (bus_a.state_out !== S_MEM_WR || en_a !== 6'b111000) begin
         bad++; $display("[TB] FAIL sw_mem: got state=%0d en=%b want %0d 111000", bus_a.state_out, en_a, S_MEM_WR);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (bus_a.state_out !== S_IDLE || en_a !== 6'b0 || bus_a.retired !== 32'd0) begin
         bad++; $display("[TB] FAIL abort_reset: got state=%0d en=%b ret=%0d want %0d 000000 0", bus_a.state_out, en_a, bus_a.retired, S_IDLE);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_wrap_jalr;
      op = OP_JALR; f3 = 3'b000; ready = 1'b1;
      do_reset;
      tick;
      for (int k = 0; k < 17; k++) begin
         tick; tick;
         if (k == 0) begin
            total++;
            if (bus_b.state_out !== S_EX_JALR || bus_b.PCSource !== 2'd2 || bus_b.MemtoReg !== 2'd2 || en_b !== 6'b000011 || bus_b.ALUSrc_A !== 1'b1) begin
               bad++; $display("[TB] FAIL jalr_ctrl: got state=%0d pcs=%0d mtr=%0d en=%b", bus_b.state_out, bus_b.PCSource, bus_b.MemtoReg, en_b);
            end
         end
         tick;
      end
      total++;
      if (bus_b.retired !== 4'd1 || bus_a.retired !== 32'd17) begin
         bad++; $display("[TB] FAIL retired_wrap: got %0d/%0d want 1/17", bus_b.retired, bus_a.retired);
      end
   endtask

   task automatic test_back_to_back;
      logic [4:0] ops[8] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_LUI, OP_JALR};
      int         lat[8] = '{4, 4, 5, 4, 3, 3, 3, 3};
      int         cnt;
      f3 = 3'b000; f7 = 1'b0; zero = 1'b0; ready = 1'b1;
      do_reset;
      tick;
      for (int i = 0; i < 8; i++) begin
         op = ops[i];
         cnt = 0;
         do begin
            tick;
            cnt++;
         end while (bus_a.state_out !== S_IF && cnt < 20);
         total++;
         if (cnt !== lat[i]) begin bad++; $display("[TB] FAIL latency_op%0d: got %0d cycles want %0d", i, cnt, lat[i]); end
      end
      total++;
      if (bus_a.retired !== 32'd8) begin bad++; $display("[TB] FAIL b2b_retired: got %0d want 8", bus_a.retired); end
   endtask

   initial begin
      test_reset;
      test_r_type;
      test_i_type;
      test_load_wait;
      test_timeout;
      test_branch;
      test_illegal_and_abort;
      test_wrap_jalr;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
